// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed seven-segment driver that snapshots the time word once per refresh frame.
// Build option SEG7_LEADING_ZERO_BLANK_EN: digits 3..1 go dark while they and every digit above are zero.

module seg7_scan_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] disp_num,
    input  logic [3:0]  point,
    input  logic        blank,
    output logic [3:0]  AN,
    output logic [7:0]  SEGMENT
);

    localparam int PCNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SCAN_DIV - 1);

    logic [PCNT_W-1:0] r_pcnt;
    logic [1:0]        r_idx;
    logic [15:0]       r_shadow_num;
    logic [3:0]        r_shadow_pt;
    logic [3:0]        r_an;
    logic [7:0]        r_seg;

    logic              w_tick;
    logic              w_frame_end;
    logic [3:0]        w_nibble;
    logic [6:0]        w_seg_lit;
    logic              w_dp_n;
    logic              w_lead_zero;
    logic [3:0]        w_an_sel;

    // Segment pattern for one hex digit, bit order g,f,e,d,c,b,a, active low.
    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    assign w_tick      = (r_pcnt == PCNT_LAST);
    assign w_frame_end = w_tick && (r_idx == 2'd3);

    // Shadow registers only load at the frame boundary so a carry mid-frame cannot tear the display.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcnt       <= '0;
            r_idx        <= 2'd0;
            r_shadow_num <= 16'h0000;
            r_shadow_pt  <= 4'b0000;
        end else begin
            if (w_tick) begin
                r_pcnt <= '0;
                r_idx  <= r_idx + 2'd1;
            end else begin
                r_pcnt <= r_pcnt + PCNT_W'(1);
            end
            if (w_frame_end) begin
                r_shadow_num <= disp_num;
                r_shadow_pt  <= point;
            end
        end
    end

    always_comb begin
        w_nibble = r_shadow_num[3:0];
        case (r_idx)
            2'd0:    w_nibble = r_shadow_num[3:0];
            2'd1:    w_nibble = r_shadow_num[7:4];
            2'd2:    w_nibble = r_shadow_num[11:8];
            2'd3:    w_nibble = r_shadow_num[15:12];
            default: w_nibble = r_shadow_num[3:0];
        endcase
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    always_comb begin
        w_lead_zero = 1'b0;
        case (r_idx)
            2'd3:    w_lead_zero = (r_shadow_num[15:12] == 4'h0);
            2'd2:    w_lead_zero = (r_shadow_num[15:8] == 8'h00);
            2'd1:    w_lead_zero = (r_shadow_num[15:4] == 12'h000);
            default: w_lead_zero = 1'b0;
        endcase
    end
`else
    assign w_lead_zero = 1'b0;
`endif

    assign w_seg_lit = w_lead_zero ? 7'h7F : f_decode(w_nibble);
    assign w_dp_n    = ~r_shadow_pt[r_idx];
    assign w_an_sel  = ~(4'b0001 << r_idx);

    // Pin-facing registers; blank only gates the outputs, scanning keeps running underneath.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an  <= 4'b1111;
            r_seg <= 8'hFF;
        end else if (blank) begin
            r_an  <= 4'b1111;
            r_seg <= 8'hFF;
        end else begin
            r_an  <= w_an_sel;
            r_seg <= {w_dp_n, w_seg_lit};
        end
    end

    assign AN      = r_an;
    assign SEGMENT = r_seg;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: a cycle-count reference model predicts every output cycle.
// Honours SEG7_LEADING_ZERO_BLANK_EN the same way the design build does.

module tb_seg7_scan_display;

    localparam int SD    = 4;
    localparam int FRAME = 4 * SD;

    logic        clk;
    logic        reset;
    logic [15:0] disp_num;
    logic [3:0]  point;
    logic        blank;
    logic [3:0]  AN;
    logic [7:0]  SEGMENT;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_t      = 0;
    logic [15:0] m_shadow_num = 16'h0000;
    logic [3:0]  m_shadow_pt  = 4'b0000;
    logic [7:0]  seg_tbl [16];

    seg7_scan_display #(.SCAN_DIV(SD)) dut (
        .clk     (clk),
        .reset   (reset),
        .disp_num(disp_num),
        .point   (point),
        .blank   (blank),
        .AN      (AN),
        .SEGMENT (SEGMENT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] a_an, input logic [7:0] a_seg,
                         input logic [3:0] e_an, input logic [7:0] e_seg);
        n_checks++;
        if (a_an === e_an && a_seg === e_seg) n_pass++;
        else $display("FAIL %s t=%0d: AN=%b SEGMENT=%h, expected AN=%b SEGMENT=%h",
                      name, m_t, a_an, a_seg, e_an, e_seg);
    endtask

    // Reference model: the output after edge t (counted from reset release) shows digit
    // ((t-1)/SD)%4 of the frame snapshot; snapshots are taken on edges that are multiples of FRAME.
    initial begin
        int   d;
        logic lz;
        exp_t e;
        seg_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        forever begin
            @(posedge clk);
            if (reset) begin
                m_t          = 0;
                m_shadow_num = 16'h0000;
                m_shadow_pt  = 4'b0000;
                e.an  = 4'b1111;
                e.seg = 8'hFF;
            end else begin
                m_t++;
                d  = ((m_t - 1) / SD) % 4;
                lz = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                lz = (d != 0) && ((m_shadow_num >> (4 * d)) == 16'h0000);
`endif
                if (blank) begin
                    e.an  = 4'b1111;
                    e.seg = 8'hFF;
                end else begin
                    e.an       = ~(4'b0001 << d);
                    e.seg      = seg_tbl[(m_shadow_num >> (4 * d)) & 16'hF];
                    if (lz) e.seg[6:0] = 7'h7F;
                    e.seg[7]   = ~m_shadow_pt[d];
                end
                if (m_t % FRAME == 0) begin
                    m_shadow_num = disp_num;
                    m_shadow_pt  = point;
                end
            end
            q_exp.push_back(e);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                check("scan", AN, SEGMENT, e.an, e.seg);
            end
        end
    end

    task automatic wait_idx(input int want);
        for (int i = 0; i < 2 * FRAME && ((m_t / SD) % 4) != want; i++) @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        disp_num = 16'h1234;
        point    = 4'b0000;
        blank    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("release", AN, SEGMENT, 4'b1110, 8'hC0);
        repeat (2 * FRAME + 4) @(negedge clk);

        wait_idx(1);
        disp_num = 16'h5678;
        repeat (2 * FRAME + 3) @(negedge clk);

        disp_num = 16'hABCD;
        point    = 4'b1100;
        repeat (2 * FRAME + 2) @(negedge clk);

        wait_idx(1);
        repeat (2) @(negedge clk);
        blank = 1'b1;
        @(negedge clk);
        check("blank_on", AN, SEGMENT, 4'b1111, 8'hFF);
        repeat (5) @(negedge clk);
        check("blank_hold", AN, SEGMENT, 4'b1111, 8'hFF);
        blank = 1'b0;
        repeat (FRAME + 3) @(negedge clk);

        disp_num = 16'h9999;
        point    = 4'b0000;
        repeat (2 * FRAME) @(negedge clk);
        wait_idx(2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_pulse", AN, SEGMENT, 4'b1111, 8'hFF);
        reset = 1'b0;
        @(negedge clk);
        check("reset_recover", AN, SEGMENT, 4'b1110, 8'hC0);
        repeat (2 * FRAME) @(negedge clk);

        disp_num = 16'h0050;
        repeat (2 * FRAME + 1) @(negedge clk);
        disp_num = 16'h0000;
        point    = 4'b1010;
        repeat (2 * FRAME) @(negedge clk);

        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 9) < 4) disp_num = 16'($urandom_range(0, 300));
            else                          disp_num = 16'($urandom);
            point = 4'($urandom);
            blank = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            repeat ($urandom_range(1, 12)) @(negedge clk);
        end
        blank = 1'b0;
        repeat (FRAME) @(negedge clk);

        if (n_checks < 12) begin
            n_checks++;
            $display("FAIL check_count: made=%0d, expected at least 12", n_checks - 1);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
